// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Brief    : Commit, dCache-write and load-forward signals of the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int ARCH_BITS = 32
);
  logic                 cmtEn;
  logic [ARCH_BITS-1:0] cmtAddr;
  logic [ARCH_BITS-1:0] cmtData;
  logic                 cmtByte;
  logic                 sbFull;
  logic                 sbEmpty;
  logic                 sbOverflow;
  logic                 dcReq;
  logic [ARCH_BITS-1:0] dcAddr;
  logic [ARCH_BITS-1:0] dcData;
  logic                 dcByte;
  logic                 dcAck;
  logic [ARCH_BITS-1:0] ldAddr;
  logic                 ldByte;
  logic                 fwdHit;
  logic [ARCH_BITS-1:0] fwdData;
  logic                 fwdStall;

  modport slave (
    input  cmtEn, cmtAddr, cmtData, cmtByte, dcAck, ldAddr, ldByte,
    output sbFull, sbEmpty, sbOverflow, dcReq, dcAddr, dcData, dcByte,
           fwdHit, fwdData, fwdStall
  );

  modport master (
    output cmtEn, cmtAddr, cmtData, cmtByte, dcAck, ldAddr, ldByte,
    input  sbFull, sbEmpty, sbOverflow, dcReq, dcAddr, dcData, dcByte,
           fwdHit, fwdData, fwdStall
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : In-order committed-store FIFO draining to the dCache, with
//            zero-latency load forwarding from buffered and committing stores.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int ARCH_BITS   = 32,
  parameter int SB_SLOTS    = 4,
  parameter int SB_IDX_BITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);

  logic [ARCH_BITS-1:0]   r_addr [SB_SLOTS];
  logic [ARCH_BITS-1:0]   r_data [SB_SLOTS];
  logic [SB_SLOTS-1:0]    r_byte;
  logic [SB_IDX_BITS-1:0] r_head;
  logic [SB_IDX_BITS-1:0] r_tail;
  logic [SB_IDX_BITS:0]   r_count;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  logic [SB_IDX_BITS-1:0] w_idx;
  logic                   w_found;
  logic                   w_fbyte;
  logic [ARCH_BITS-1:0]   w_fdata;
  logic [ARCH_BITS-1:0]   w_lane;

  assign w_full  = (r_count == (SB_IDX_BITS+1)'(SB_SLOTS));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && sb.dcAck;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign w_push  = sb.cmtEn && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SB_SLOTS; s++) begin
        r_addr[s] <= '0;
        r_data[s] <= '0;
      end
      r_byte <= '0;
    end else if (w_push) begin
      r_addr[r_tail] <= sb.cmtAddr;
      r_data[r_tail] <= sb.cmtData;
      r_byte[r_tail] <= sb.cmtByte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + SB_IDX_BITS'(1);
      end
      if (w_pop) begin
        r_head <= r_head + SB_IDX_BITS'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (SB_IDX_BITS+1)'(1);
        2'b01:   r_count <= r_count - (SB_IDX_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
      if (sb.cmtEn && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign sb.sbFull     = w_full;
  assign sb.sbEmpty    = w_empty;
  assign sb.sbOverflow = r_overflow;
  assign sb.dcReq      = !w_empty;
  assign sb.dcAddr     = r_addr[r_head];
  assign sb.dcData     = r_data[r_head];
  assign sb.dcByte     = r_byte[r_head];

  // Byte-vs-byte needs the same lane; any other pairing overlaps on word match.
  function automatic logic f_overlap(
    input logic [ARCH_BITS-1:0] e_addr,
    input logic                 e_byte,
    input logic [ARCH_BITS-1:0] l_addr,
    input logic                 l_byte
  );
    f_overlap = (e_addr[ARCH_BITS-1:2] == l_addr[ARCH_BITS-1:2]) &&
                !(e_byte && l_byte && (e_addr[1:0] != l_addr[1:0]));
  endfunction

  // Walk oldest to youngest so the last overlapping candidate wins.
  always_comb begin
    w_found = 1'b0;
    w_fbyte = 1'b0;
    w_fdata = '0;
    w_idx   = r_head;
    for (int k = 0; k < SB_SLOTS; k++) begin
      w_idx = r_head + SB_IDX_BITS'(k);
      if (((SB_IDX_BITS+1)'(k) < r_count) &&
          f_overlap(r_addr[w_idx], r_byte[w_idx], sb.ldAddr, sb.ldByte)) begin
        w_found = 1'b1;
        w_fbyte = r_byte[w_idx];
        w_fdata = r_data[w_idx];
      end
    end
    if (sb.cmtEn && f_overlap(sb.cmtAddr, sb.cmtByte, sb.ldAddr, sb.ldByte)) begin
      w_found = 1'b1;
      w_fbyte = sb.cmtByte;
      w_fdata = sb.cmtData;
    end
  end

  assign w_lane = w_fdata >> {sb.ldAddr[1:0], 3'b000};

  always_comb begin
    sb.fwdHit   = 1'b0;
    sb.fwdStall = 1'b0;
    sb.fwdData  = '0;
    if (w_found) begin
      if (w_fbyte && !sb.ldByte) begin
        sb.fwdStall = 1'b1;
      end else begin
        sb.fwdHit = 1'b1;
        if (w_fbyte) begin
          sb.fwdData = ARCH_BITS'(w_fdata[7:0]);
        end else if (sb.ldByte) begin
          sb.fwdData = ARCH_BITS'(w_lane[7:0]);
        end else begin
          sb.fwdData = w_fdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed and random stimulus against a queue-based store model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  logic clk;
  logic rst;

  store_buffer_if #(.ARCH_BITS(32)) sbi ();

  store_buffer #(
    .ARCH_BITS  (32),
    .SB_SLOTS   (4),
    .SB_IDX_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        byt;
  } st_t;

  st_t mq[$];
  bit  m_ovf;
  bit  m_live;
  int  checks;
  int  errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: in-order queue of accepted stores.
  always @(posedge clk) begin
    bit pop;
    bit acc;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      pop = (mq.size() > 0) && sbi.dcAck;
      acc = sbi.cmtEn && ((mq.size() < 4) || pop);
      if (sbi.cmtEn && !acc) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{sbi.cmtAddr, sbi.cmtData, sbi.cmtByte});
    end
  end

  // Youngest-first search over buffered stores plus the committing one.
  function automatic void model_fwd(output bit hit, output bit stall, output logic [31:0] d);
    st_t c[$];
    c = mq;
    if (sbi.cmtEn) c.push_back('{sbi.cmtAddr, sbi.cmtData, sbi.cmtByte});
    hit = 0; stall = 0; d = 0;
    for (int i = c.size() - 1; i >= 0; i--) begin
      if (c[i].addr[31:2] == sbi.ldAddr[31:2] &&
          (!(c[i].byt && sbi.ldByte) || c[i].addr[1:0] == sbi.ldAddr[1:0])) begin
        if (c[i].byt && !sbi.ldByte) stall = 1;
        else begin
          hit = 1;
          if (!sbi.ldByte) d = c[i].data;
          else if (c[i].byt) d = {24'd0, c[i].data[7:0]};
          else d = (c[i].data >> (8 * sbi.ldAddr[1:0])) & 32'hFF;
        end
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    int n;
    bit eh;
    bit es;
    logic [31:0] ed;
    if (m_live) begin
      n = mq.size();
      chk("sbFull", sbi.sbFull, n == 4);
      chk("sbEmpty", sbi.sbEmpty, n == 0);
      chk("sbOverflow", sbi.sbOverflow, m_ovf);
      chk("dcReq", sbi.dcReq, n > 0);
      if (n > 0) begin
        chk("dcAddr", sbi.dcAddr, mq[0].addr);
        chk("dcData", sbi.dcData, mq[0].data);
        chk("dcByte", sbi.dcByte, mq[0].byt);
      end
      model_fwd(eh, es, ed);
      chk("fwdHit", sbi.fwdHit, eh);
      chk("fwdStall", sbi.fwdStall, es);
      if (!es) chk("fwdData", sbi.fwdData, ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sbi.cmtEn = 1'b0; sbi.dcAck = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic b);
    sbi.cmtEn = 1'b1; sbi.cmtAddr = a; sbi.cmtData = d; sbi.cmtByte = b;
    tick();
    sbi.cmtEn = 1'b0;
  endtask

  initial begin
    int n_commit;
    int n_pop;
    int cyc;
    checks = 0; errors = 0; m_live = 1'b0; m_ovf = 1'b0;
    rst = 1'b1;
    sbi.cmtEn = 0; sbi.cmtAddr = 0; sbi.cmtData = 0; sbi.cmtByte = 0;
    sbi.dcAck = 0; sbi.ldAddr = 32'h0; sbi.ldByte = 0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", sbi.sbEmpty, 1);
    chk("rst_full", sbi.sbFull, 0);
    chk("rst_dcReq", sbi.dcReq, 0);
    chk("rst_fwd", {sbi.fwdHit, sbi.fwdStall, sbi.fwdData[29:0]}, 0);

    // Single word store held until acked.
    tick();
    commit(32'h100, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req", sbi.dcReq, 1);
      chk("hold_addr", sbi.dcAddr, 32'h100);
      chk("hold_data", sbi.dcData, 32'hDEADBEEF);
      tick();
    end
    sbi.dcAck = 1'b1;
    tick();
    sbi.dcAck = 1'b0;
    @(negedge clk);
    chk("ack_empty", sbi.sbEmpty, 1);

    // Full and overflow, then full with simultaneous pop.
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) commit(32'h10 + 4 * i, 32'hA0 + i, 1'b0);
    @(negedge clk);
    chk("fill_full", sbi.sbFull, 1);
    tick();
    commit(32'h20, 32'hFF, 1'b0);
    @(negedge clk);
    chk("ovf_set", sbi.sbOverflow, 1);
    chk("ovf_full", sbi.sbFull, 1);
    chk("ovf_head", sbi.dcAddr, 32'h10);
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) commit(32'h10 + 4 * i, 32'hA0 + i, 1'b0);
    sbi.dcAck = 1'b1;
    commit(32'h20, 32'hFF, 1'b0);
    sbi.dcAck = 1'b0;
    @(negedge clk);
    chk("pp_full", sbi.sbFull, 1);
    chk("pp_ovf", sbi.sbOverflow, 0);
    chk("pp_head", sbi.dcAddr, 32'h14);

    // Forwarding lanes and partial overlap.
    tick();
    do_reset();
    commit(32'h200, 32'h11223344, 1'b0);
    commit(32'h201, 32'h000000AA, 1'b1);
    sbi.ldAddr = 32'h201; sbi.ldByte = 1'b1; #1;
    chk("fwd_b201_hit", sbi.fwdHit, 1);
    chk("fwd_b201_data", sbi.fwdData, 32'hAA);
    sbi.ldAddr = 32'h202; #1;
    chk("fwd_b202_hit", sbi.fwdHit, 1);
    chk("fwd_b202_data", sbi.fwdData, 32'h22);
    sbi.ldAddr = 32'h200; sbi.ldByte = 1'b0; #1;
    chk("fwd_w200_stall", sbi.fwdStall, 1);
    chk("fwd_w200_hit", sbi.fwdHit, 0);
    commit(32'h300, 32'h1, 1'b0);
    sbi.cmtEn = 1'b1; sbi.cmtAddr = 32'h300; sbi.cmtData = 32'h2; sbi.cmtByte = 1'b0;
    sbi.ldAddr = 32'h300; #1;
    chk("fwd_cmt_hit", sbi.fwdHit, 1);
    chk("fwd_cmt_data", sbi.fwdData, 32'h2);
    tick();
    sbi.cmtEn = 1'b0;

    // Drain with ack every other cycle across wraps.
    do_reset();
    n_commit = 0; n_pop = 0; cyc = 0;
    while (n_pop < 10 && cyc < 300) begin
      sbi.cmtEn = (n_commit < 10) && !sbi.sbFull;
      sbi.cmtAddr = 32'h1000 + 4 * n_commit;
      sbi.cmtData = $urandom; sbi.cmtByte = 1'b0;
      if (sbi.cmtEn) n_commit++;
      sbi.dcAck = cyc[0];
      @(negedge clk);
      if (sbi.dcReq && sbi.dcAck) begin
        chk("drain_order", sbi.dcAddr, 32'h1000 + 4 * n_pop);
        n_pop++;
      end
      tick();
      cyc++;
    end
    chk("drain_count", n_pop, 10);
    sbi.cmtEn = 1'b0; sbi.dcAck = 1'b0;

    // Reset mid-drain discards entries.
    commit(32'h500, 32'h5, 1'b0);
    commit(32'h504, 32'h6, 1'b0);
    commit(32'h508, 32'h7, 1'b0);
    rst = 1'b1; sbi.dcAck = 1'b1; sbi.ldAddr = 32'h504; sbi.ldByte = 1'b0;
    tick();
    rst = 1'b0; sbi.dcAck = 1'b0;
    @(negedge clk);
    chk("rst_mid_empty", sbi.sbEmpty, 1);
    chk("rst_mid_req", sbi.dcReq, 0);
    chk("rst_mid_hit", sbi.fwdHit, 0);
    tick();

    // Random traffic over a small address window.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      sbi.cmtEn = $urandom_range(0, 1);
      sbi.cmtAddr = 32'h400 + $urandom_range(0, 15);
      sbi.cmtData = $urandom;
      sbi.cmtByte = $urandom_range(0, 1);
      sbi.dcAck = ($urandom_range(0, 2) == 0);
      sbi.ldAddr = 32'h400 + $urandom_range(0, 15);
      sbi.ldByte = $urandom_range(0, 1);
      tick();
    end
    rst = 1'b0; sbi.cmtEn = 1'b0; sbi.dcAck = 1'b0;
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
